mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH_BIT, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH_BIT, default 32, request and response data width.
REQ-004 SHALL have parameter TAG_WIDTH_BIT, default 1, requester-side tag width.
REQ-005 SHALL have parameter MAX_PENDING, default 4, maximum outstanding reads (power of two).
REQ-006 SHALL use one clock, clk_i (input, 1), with all state updated on its rising edge.
REQ-007 SHALL use reset rst_i (input, 1), which is synchronous and active-high.
REQ-008 SHALL have in_req_valid_i, in_req_rw_i, in_req_ready_o, each NUM_REQS bits wide, indexed per requester; rw=1 means write.
REQ-009 SHALL have in_req_addr_i (input, NUM_REQS*ADDR_WIDTH_BIT), in_req_data_i (input, NUM_REQS*DATA_WIDTH_BIT), in_req_byteen_i (input, NUM_REQS*DATA_WIDTH_BIT/8) and in_req_tag_i (input, NUM_REQS*TAG_WIDTH_BIT), each a flattened per-requester request field.
REQ-010 SHALL have in_rsp_valid_o (output, NUM_REQS), in_rsp_ready_i (input, NUM_REQS), in_rsp_data_o (output, DATA_WIDTH_BIT) and in_rsp_tag_o (output, TAG_WIDTH_BIT); data and tag are shared by all requesters.
REQ-011 SHALL have out_req_valid_o (output, 1), out_req_ready_i (input, 1), out_req_rw_o (output, 1), out_req_addr_o (output, ADDR_WIDTH_BIT), out_req_data_o (output, DATA_WIDTH_BIT), out_req_byteen_o (output, DATA_WIDTH_BIT/8) and out_req_tag_o (output, OTW), where OTW = TAG_WIDTH_BIT + $clog2(NUM_REQS).
REQ-012 SHALL have out_rsp_valid_i (input, 1), out_rsp_ready_o (output, 1), out_rsp_data_i (input, DATA_WIDTH_BIT) and out_rsp_tag_i (input, OTW).

Function
REQ-013 SHALL implement FSM states IDLE and ISSUE.
REQ-014 In IDLE with any eligible valid, SHALL select the winner round-robin starting at pointer rr_ptr, pulse in_req_ready_o for the winner only, register its request and go to ISSUE in the same cycle.
REQ-015 A read request is eligible only when pending < MAX_PENDING; a write request is always eligible.
REQ-016 In ISSUE, SHALL hold out_req_valid_o=1 and all out_req fields stable until out_req_ready_i=1, then return to IDLE; minimum issue interval is 2 cycles.
REQ-017 SHALL set out_req_tag_o = {winner index, winner tag}, with the index in the MSBs.
REQ-018 On grant, SHALL set rr_ptr = (winner+1) mod NUM_REQS; with no grant, rr_ptr is unchanged.
REQ-019 SHALL increment pending on each accepted read handshake (out_req_valid_o & out_req_ready_i & !rw) and decrement it on each response handshake; when both occur in the same cycle, pending is unchanged.
REQ-020 Writes SHALL produce no response and SHALL NOT affect pending.
REQ-021 Response routing SHALL be combinational: in_rsp_valid_o[idx] = out_rsp_valid_i, with idx taken from the tag MSBs; in_rsp_tag_o = tag LSBs; in_rsp_data_o = out_rsp_data_i; out_rsp_ready_o = in_rsp_ready_i[idx].
REQ-022 A response whose index is >= NUM_REQS SHALL be accepted (ready=1) and dropped.
REQ-023 Pending SHALL saturate: no underflow at 0, no overflow at MAX_PENDING.

Reset
REQ-024 While rst_i=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, pending=0 and clear all registered request fields.
REQ-025 During reset, SHALL drive out_req_valid_o=0 and in_req_ready_o=0; in_rsp_valid_o and out_rsp_ready_o follow REQ-021.
REQ-026 Reset asserted in ISSUE SHALL drop the held request without a handshake.

Configuration
REQ-027 With macro MEM_ARB_PENDING_LIMIT_EN defined, SHALL implement the pending counter and read throttling of REQ-015, REQ-019 and REQ-023.
REQ-028 Without MEM_ARB_PENDING_LIMIT_EN, SHALL omit the pending counter, treat all reads as eligible and leave MAX_PENDING unused.

Verification
REQ-029 Bench SHALL cover: NUM_REQS=2, both valid continuously at reset release -> grants alternate 0,1,0,1; out_req_tag_o MSB alternates.
REQ-030 Bench SHALL cover: req1 read with tag 1 accepted, response with out_rsp_tag_i=2'b11 and data 0xDEADBEEF -> in_rsp_valid_o=2'b10, in_rsp_tag_o=1, in_rsp_data_o=0xDEADBEEF.
REQ-031 Bench SHALL cover: out_req_ready_i held low 5 cycles in ISSUE -> out_req fields stable, no in_req_ready_o pulse.
REQ-032 Bench SHALL cover, with the macro defined: 4 reads issued and no responses -> 5th read stalls while a write from another requester is still granted; one response -> the read issues.
REQ-033 Bench SHALL cover: issue handshake and response handshake in the same cycle at pending=2 -> pending stays 2.
REQ-034 Bench SHALL cover: rst_i asserted in ISSUE -> next cycle out_req_valid_o=0, rr_ptr=0, pending=0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin N:1 memory request arbiter with tag-routed, combinational response return.
// Optional build macro MEM_ARB_PENDING_LIMIT_EN: throttle reads once MAX_PENDING are outstanding.

module mem_req_arbiter #(
  parameter int unsigned NUM_REQS       = 2,
  parameter int unsigned ADDR_WIDTH_BIT = 32,
  parameter int unsigned DATA_WIDTH_BIT = 32,
  parameter int unsigned TAG_WIDTH_BIT  = 1,
  parameter int unsigned MAX_PENDING    = 4,
  localparam int unsigned IDX_W         = $clog2(NUM_REQS),
  localparam int unsigned OTW           = TAG_WIDTH_BIT + IDX_W,
  localparam int unsigned BE_W          = DATA_WIDTH_BIT / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  // requester side
  input  logic [NUM_REQS-1:0]                  in_req_valid_i,
  input  logic [NUM_REQS-1:0]                  in_req_rw_i,
  input  logic [NUM_REQS*ADDR_WIDTH_BIT-1:0]   in_req_addr_i,
  input  logic [NUM_REQS*DATA_WIDTH_BIT-1:0]   in_req_data_i,
  input  logic [NUM_REQS*BE_W-1:0]             in_req_byteen_i,
  input  logic [NUM_REQS*TAG_WIDTH_BIT-1:0]    in_req_tag_i,
  output logic [NUM_REQS-1:0]                  in_req_ready_o,
  output logic [NUM_REQS-1:0]                  in_rsp_valid_o,
  input  logic [NUM_REQS-1:0]                  in_rsp_ready_i,
  output logic [DATA_WIDTH_BIT-1:0]            in_rsp_data_o,
  output logic [TAG_WIDTH_BIT-1:0]             in_rsp_tag_o,
  // memory side
  output logic                                 out_req_valid_o,
  input  logic                                 out_req_ready_i,
  output logic                                 out_req_rw_o,
  output logic [ADDR_WIDTH_BIT-1:0]            out_req_addr_o,
  output logic [DATA_WIDTH_BIT-1:0]            out_req_data_o,
  output logic [BE_W-1:0]                      out_req_byteen_o,
  output logic [OTW-1:0]                       out_req_tag_o,
  input  logic                                 out_rsp_valid_i,
  output logic                                 out_rsp_ready_o,
  input  logic [DATA_WIDTH_BIT-1:0]            out_rsp_data_i,
  input  logic [OTW-1:0]                       out_rsp_tag_i
);

  if (NUM_REQS < 2 || NUM_REQS > 8) begin : g_bad_num_reqs
    $error("mem_req_arbiter: NUM_REQS must be in 2..8");
  end
  if (MAX_PENDING == 0 || (MAX_PENDING & (MAX_PENDING - 1)) != 0) begin : g_bad_max_pending
    $error("mem_req_arbiter: MAX_PENDING must be a power of two");
  end

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      req_rw_q, req_rw_d;
  logic [ADDR_WIDTH_BIT-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH_BIT-1:0] req_data_q, req_data_d;
  logic [BE_W-1:0]           req_byteen_q, req_byteen_d;
  logic [OTW-1:0]            req_tag_q, req_tag_d;

  logic                      read_ok;
  logic [NUM_REQS-1:0]       eligible;
  logic                      grant_found;
  logic [IDX_W-1:0]          grant_idx;
  int unsigned               cand;
  logic                      do_grant;
  logic                      out_hs;
  logic                      sel_rw;
  logic [ADDR_WIDTH_BIT-1:0] sel_addr;
  logic [DATA_WIDTH_BIT-1:0] sel_data;
  logic [BE_W-1:0]           sel_byteen;
  logic [OTW-1:0]            sel_tag;
  logic [IDX_W-1:0]          rsp_idx;

`ifdef MEM_ARB_PENDING_LIMIT_EN
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  logic [PEND_W-1:0] pending_q, pending_d;
  logic              rd_issue;
  logic              rsp_hs;

  assign read_ok  = pending_q < PEND_W'(MAX_PENDING);
  assign rd_issue = out_hs & ~req_rw_q;
  assign rsp_hs   = out_rsp_valid_i & out_rsp_ready_o;

  // Simultaneous issue and response cancel out; both ends saturate.
  always_comb begin
    pending_d = pending_q;
    if (rd_issue && !rsp_hs && pending_q != PEND_W'(MAX_PENDING)) begin
      pending_d = pending_q + 1'b1;
    end else if (!rd_issue && rsp_hs && pending_q != '0) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign read_ok = 1'b1;
`endif

  assign eligible = in_req_valid_i & (in_req_rw_i | {NUM_REQS{read_ok}});

  // First eligible requester at or after rr_ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQS;
      if (!grant_found && eligible[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    sel_rw     = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_byteen = '0;
    sel_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rw     = in_req_rw_i[i];
        sel_addr   = in_req_addr_i[i*ADDR_WIDTH_BIT +: ADDR_WIDTH_BIT];
        sel_data   = in_req_data_i[i*DATA_WIDTH_BIT +: DATA_WIDTH_BIT];
        sel_byteen = in_req_byteen_i[i*BE_W +: BE_W];
        sel_tag    = {grant_idx, in_req_tag_i[i*TAG_WIDTH_BIT +: TAG_WIDTH_BIT]};
      end
    end
  end

  assign do_grant        = (state_q == StIdle) && grant_found && !rst_i;
  assign out_req_valid_o = (state_q == StIssue) && !rst_i;
  assign out_hs          = out_req_valid_o & out_req_ready_i;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      in_req_ready_o[i] = do_grant && (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    req_rw_d     = req_rw_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_byteen_d = req_byteen_q;
    req_tag_d    = req_tag_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d      = StIssue;
          rr_ptr_d     = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
          req_rw_d     = sel_rw;
          req_addr_d   = sel_addr;
          req_data_d   = sel_data;
          req_byteen_d = sel_byteen;
          req_tag_d    = sel_tag;
        end
      end
      StIssue: begin
        if (out_req_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      req_rw_q     <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_byteen_q <= '0;
      req_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      req_rw_q     <= req_rw_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_byteen_q <= req_byteen_d;
      req_tag_q    <= req_tag_d;
    end
  end

  assign out_req_rw_o     = req_rw_q;
  assign out_req_addr_o   = req_addr_q;
  assign out_req_data_o   = req_data_q;
  assign out_req_byteen_o = req_byteen_q;
  assign out_req_tag_o    = req_tag_q;

  // Responses to an out-of-range index are accepted and go nowhere.
  assign rsp_idx       = out_rsp_tag_i[OTW-1 -: IDX_W];
  assign in_rsp_tag_o  = out_rsp_tag_i[TAG_WIDTH_BIT-1:0];
  assign in_rsp_data_o = out_rsp_data_i;

  always_comb begin
    out_rsp_ready_o = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      in_rsp_valid_o[i] = out_rsp_valid_i && (rsp_idx == IDX_W'(i));
      if (rsp_idx == IDX_W'(i)) begin
        out_rsp_ready_o = in_rsp_ready_i[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed corner cases then randomized traffic.
// Read-throttling checks are active only when MEM_ARB_PENDING_LIMIT_EN is defined.

module tb_mem_req_arbiter;
  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 1;
  localparam int MP  = 4;
  localparam int IW  = 1;
  localparam int OTW = TW + IW;
  localparam int BW  = DW / 8;
`ifdef MEM_ARB_PENDING_LIMIT_EN
  localparam int RdLimit = MP;
`else
  localparam int RdLimit = 1 << 30;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    in_req_valid_i, in_req_rw_i, in_req_ready_o;
  logic [N*AW-1:0] in_req_addr_i;
  logic [N*DW-1:0] in_req_data_i;
  logic [N*BW-1:0] in_req_byteen_i;
  logic [N*TW-1:0] in_req_tag_i;
  logic [N-1:0]    in_rsp_valid_o, in_rsp_ready_i;
  logic [DW-1:0]   in_rsp_data_o;
  logic [TW-1:0]   in_rsp_tag_o;
  logic            out_req_valid_o, out_req_ready_i, out_req_rw_o;
  logic [AW-1:0]   out_req_addr_o;
  logic [DW-1:0]   out_req_data_o;
  logic [BW-1:0]   out_req_byteen_o;
  logic [OTW-1:0]  out_req_tag_o;
  logic            out_rsp_valid_i, out_rsp_ready_o;
  logic [DW-1:0]   out_rsp_data_i;
  logic [OTW-1:0]  out_rsp_tag_i;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  logic [BW-1:0] be_a   [N];
  logic [TW-1:0] tag_a  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign in_req_addr_i[g*AW +: AW]   = addr_a[g];
    assign in_req_data_i[g*DW +: DW]   = data_a[g];
    assign in_req_byteen_i[g*BW +: BW] = be_a[g];
    assign in_req_tag_i[g*TW +: TW]    = tag_a[g];
  end

  mem_req_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_req_valid_i   (in_req_valid_i),
    .in_req_rw_i      (in_req_rw_i),
    .in_req_addr_i    (in_req_addr_i),
    .in_req_data_i    (in_req_data_i),
    .in_req_byteen_i  (in_req_byteen_i),
    .in_req_tag_i     (in_req_tag_i),
    .in_req_ready_o   (in_req_ready_o),
    .in_rsp_valid_o   (in_rsp_valid_o),
    .in_rsp_ready_i   (in_rsp_ready_i),
    .in_rsp_data_o    (in_rsp_data_o),
    .in_rsp_tag_o     (in_rsp_tag_o),
    .out_req_valid_o  (out_req_valid_o),
    .out_req_ready_i  (out_req_ready_i),
    .out_req_rw_o     (out_req_rw_o),
    .out_req_addr_o   (out_req_addr_o),
    .out_req_data_o   (out_req_data_o),
    .out_req_byteen_o (out_req_byteen_o),
    .out_req_tag_o    (out_req_tag_o),
    .out_rsp_valid_i  (out_rsp_valid_i),
    .out_rsp_ready_o  (out_rsp_ready_o),
    .out_rsp_data_i   (out_rsp_data_i),
    .out_rsp_tag_i    (out_rsp_tag_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [OTW-1:0] tag;
  } req_t;

  typedef struct {
    logic [N-1:0]  vld;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          rdy;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  // Reference model: busy flag, round-robin start index, outstanding-read count.
  bit   m_busy = 1'b0;
  int   m_rr   = 0;
  int   m_pend = 0;
  logic m_cur_rw = 1'b0;

  task automatic model_eval();
    logic [N-1:0] exp_rdy;
    int   w;
    bit   rsp_hs;
    bit   rd_hs;
    int   idx;
    int   c;
    rsp_t r;
    req_t q;
    exp_rdy = '0;
    w       = -1;
    rsp_hs  = 1'b0;
    if (out_rsp_valid_i) begin
      idx   = int'(out_rsp_tag_i[OTW-1 -: IW]);
      r.vld = '0;
      r.rdy = 1'b1;
      if (idx < N) begin
        r.vld[idx] = 1'b1;
        r.rdy      = in_rsp_ready_i[idx];
      end
      r.tag  = out_rsp_tag_i[TW-1:0];
      r.data = out_rsp_data_i;
      exp_rsp_q.push_back(r);
      rsp_hs = r.rdy;
    end
    if (!rst && !m_busy) begin
      for (int off = 0; off < N; off++) begin
        c = (m_rr + off) % N;
        if (w < 0 && in_req_valid_i[c] && (in_req_rw_i[c] || m_pend < RdLimit)) w = c;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("in_req_ready", in_req_ready_o, exp_rdy);
    check("out_req_valid", out_req_valid_o, m_busy && !rst);
    if (rst) begin
      m_busy = 1'b0;
      m_rr   = 0;
      m_pend = 0;
      exp_req_q.delete();
    end else begin
      rd_hs = m_busy && out_req_ready_i && !m_cur_rw;
      if (m_busy && out_req_ready_i) m_busy = 1'b0;
      if (w >= 0) begin
        q.rw   = in_req_rw_i[w];
        q.addr = addr_a[w];
        q.data = data_a[w];
        q.be   = be_a[w];
        q.tag  = {IW'(w), tag_a[w]};
        exp_req_q.push_back(q);
        m_busy   = 1'b1;
        m_cur_rw = q.rw;
        m_rr     = (w + 1) % N;
      end
      m_pend = m_pend + int'(rd_hs) - int'(rsp_hs);
      if (m_pend < 0) m_pend = 0;
      if (m_pend > MP) m_pend = MP;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic advance();
    model_eval();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  // Memory-side request monitor.
  always @(negedge clk) begin
    #2;
    if (out_req_valid_o) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_req_unexpected: got valid=1 expected no request (t=%0t)", $time);
      end else begin
        check("out_req_fields",
              {out_req_rw_o, out_req_addr_o, out_req_data_o, out_req_byteen_o, out_req_tag_o},
              {exp_req_q[0].rw, exp_req_q[0].addr, exp_req_q[0].data, exp_req_q[0].be,
               exp_req_q[0].tag});
        if (out_req_ready_i) void'(exp_req_q.pop_front());
      end
    end
  end

  // Requester-side response monitor.
  always @(negedge clk) begin
    rsp_t e;
    #2;
    if (exp_rsp_q.size() != 0) begin
      e = exp_rsp_q.pop_front();
      check("in_rsp", {in_rsp_valid_o, in_rsp_tag_o, in_rsp_data_o, out_rsp_ready_o},
            {e.vld, e.tag, e.data, e.rdy});
    end else if (in_rsp_valid_o != '0) begin
      checks++;
      errors++;
      $display("FAIL in_rsp_unexpected: got valid=%0b expected 0 (t=%0t)", in_rsp_valid_o, $time);
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [TW-1:0] t);
    addr_a[i] = a;
    data_a[i] = d;
    be_a[i]   = 4'hF;
    tag_a[i]  = t;
  endtask

  initial begin
    rst = 1'b1;
    in_req_valid_i = '0;
    in_req_rw_i = '0;
    out_req_ready_i = 1'b0;
    out_rsp_valid_i = 1'b0;
    out_rsp_tag_i = '0;
    out_rsp_data_i = '0;
    in_rsp_ready_i = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'h1000 + 32'(i), 32'hD000 + 32'(i), TW'(i));
    @(negedge clk);

    // Both writers valid through reset release: grants alternate 0,1,0,1.
    in_req_valid_i = 2'b11;
    in_req_rw_i = 2'b11;
    step();
    step();
    rst = 1'b0;
    out_req_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (c % 2 == 0) check("alt_grant", in_req_ready_o, (c % 4 == 0) ? 2'b01 : 2'b10);
      else            check("alt_tag_msb", out_req_tag_o[OTW-1], (c % 4 == 1) ? 1'b0 : 1'b1);
      advance();
    end

    // Read from requester 1 with tag 1, response routed back to it.
    in_req_valid_i = 2'b10;
    in_req_rw_i = 2'b00;
    tag_a[1] = 1'b1;
    step();
    in_req_valid_i = 2'b00;
    step();
    out_rsp_valid_i = 1'b1;
    out_rsp_tag_i = 2'b11;
    out_rsp_data_i = 32'hDEADBEEF;
    settle();
    check("rsp_route", {in_rsp_valid_o, in_rsp_tag_o, in_rsp_data_o}, {2'b10, 1'b1, 32'hDEADBEEF});
    advance();
    out_rsp_valid_i = 1'b0;

    // Memory stalls five cycles: held request stays put, no new grants.
    in_req_valid_i = 2'b01;
    in_req_rw_i = 2'b11;
    set_req(0, 32'hA0A0_0000, 32'h1234_5678, 1'b1);
    out_req_ready_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      in_req_valid_i = 2'b11;
      addr_a[0] = $urandom;
      settle();
      check("hold_no_ready", in_req_ready_o, 2'b00);
      check("hold_addr", {out_req_valid_o, out_req_addr_o}, {1'b1, 32'hA0A0_0000});
      advance();
    end
    in_req_valid_i = 2'b00;
    out_req_ready_i = 1'b1;
    step();

    // Four reads outstanding; fifth read stalls while a write still wins.
    in_req_valid_i = 2'b11;
    in_req_rw_i = 2'b00;
    for (int c = 0; c < 8; c++) step();
    in_req_rw_i = 2'b01;
    settle();
`ifdef MEM_ARB_PENDING_LIMIT_EN
    check("limit_write_wins", in_req_ready_o, 2'b01);
`endif
    advance();
    in_req_valid_i = 2'b10;
    in_req_rw_i = 2'b00;
    for (int c = 0; c < 3; c++) begin
      settle();
`ifdef MEM_ARB_PENDING_LIMIT_EN
      check("limit_read_stalls", in_req_ready_o, 2'b00);
`endif
      advance();
    end
    out_rsp_valid_i = 1'b1;
    out_rsp_tag_i = 2'b00;
    settle();
`ifdef MEM_ARB_PENDING_LIMIT_EN
    check("limit_rsp_cycle", in_req_ready_o, 2'b00);
`endif
    advance();
    out_rsp_valid_i = 1'b0;
    settle();
`ifdef MEM_ARB_PENDING_LIMIT_EN
    check("limit_released", in_req_ready_o, 2'b10);
`endif
    advance();
    in_req_valid_i = 2'b00;
    step();

    // Drain to two outstanding, then issue and respond in the same cycle.
    out_rsp_valid_i = 1'b1;
    step();
    step();
    out_rsp_valid_i = 1'b0;
    in_req_valid_i = 2'b01;
    step();
    in_req_valid_i = 2'b00;
    out_rsp_valid_i = 1'b1;
    step();
    out_rsp_valid_i = 1'b0;
    settle();
`ifdef MEM_ARB_PENDING_LIMIT_EN
    check("pend_same_cycle", dut.pending_q, 2);
`endif
    advance();

    // Reset while a request is held.
    in_req_valid_i = 2'b01;
    in_req_rw_i = 2'b01;
    out_req_ready_i = 1'b0;
    step();
    in_req_valid_i = 2'b00;
    step();
    rst = 1'b1;
    settle();
    check("rst_drop_valid", {out_req_valid_o, in_req_ready_o}, 3'b000);
    advance();
    rst = 1'b0;
    settle();
    check("post_rst_valid", out_req_valid_o, 1'b0);
    check("post_rst_rr", dut.rr_ptr_q, 0);
`ifdef MEM_ARB_PENDING_LIMIT_EN
    check("post_rst_pend", dut.pending_q, 0);
`endif
    advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      in_req_valid_i = N'($urandom);
      in_req_rw_i = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr_a[i] = $urandom;
        data_a[i] = $urandom;
        be_a[i]   = BW'($urandom);
        tag_a[i]  = TW'($urandom);
      end
      out_req_ready_i = ($urandom_range(0, 9) < 7);
      out_rsp_valid_i = ($urandom_range(0, 4) == 0);
      out_rsp_tag_i = OTW'($urandom);
      out_rsp_data_i = $urandom;
      in_rsp_ready_i = N'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
